// File: rtl/alu_e4m3_scheduler.sv
// Round-robin scheduler sharing one e4m3 ALU among four requesters; each response
// appears ALU_LATENCY+2 cycles after its grant and is held until accepted.
module alu_e4m3_scheduler #(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  req_valid,
  output logic [3:0]  req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [7:0]  req_op,
  output logic [3:0]  rsp_valid,
  input  logic [3:0]  rsp_ready,
  output logic [31:0] rsp_y,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [7:0]  alu_y,
  output logic        busy,
  output logic [15:0] issue_count
);
  localparam int STAGES = ALU_LATENCY + 1;

  logic [1:0] ptr;
  logic [3:0] in_flight;
  logic [3:0] eligible;
  logic [1:0] win;
  logic       win_found;
  logic       issue;
  logic [1:0] op_sel;
  logic [3:0] ctrl_sel;

  logic       tag_vld  [STAGES];
  logic [1:0] tag_id   [STAGES];
  logic       tag_zero [STAGES];

  logic       cap;
  logic [1:0] cap_id;
  logic       cap_zero;

  // A requester holding an unaccepted response is not eligible, even in its accept cycle.
  assign eligible = req_valid & ~in_flight & ~rsp_valid;

  always_comb begin
    win       = ptr;
    win_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!win_found && eligible[ptr + 2'(k)]) begin
        win       = ptr + 2'(k);
        win_found = 1'b1;
      end
    end
  end

  assign req_ready = (win_found ? (4'b0001 << win) : 4'b0000) & {4{reset_n}};
  assign issue     = win_found & reset_n;
  assign op_sel    = req_op[{win, 1'b0} +: 2];

  always_comb begin
    case (op_sel)
      2'b01:   ctrl_sel = 4'b0001;
      2'b10:   ctrl_sel = 4'b0010;
      default: ctrl_sel = 4'b0000;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_a       <= 8'h00;
      alu_b       <= 8'h00;
      alu_ctrl    <= 4'b0000;
      ptr         <= 2'd0;
      issue_count <= 16'h0000;
    end else begin
      alu_ctrl <= issue ? ctrl_sel : 4'b0000;
      if (issue) begin
        alu_a       <= req_a[{win, 3'b000} +: 8];
        alu_b       <= req_b[{win, 3'b000} +: 8];
        ptr         <= win + 2'd1;
        issue_count <= issue_count + 16'd1;
      end
    end
  end

  // Illegal opcodes ride the pipe with a zero flag so their response is forced to 0x00.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < STAGES; s++) begin
        tag_vld[s]  <= 1'b0;
        tag_id[s]   <= 2'd0;
        tag_zero[s] <= 1'b0;
      end
    end else begin
      tag_vld[0]  <= issue;
      tag_id[0]   <= win;
      tag_zero[0] <= (ctrl_sel == 4'b0000);
      for (int s = 1; s < STAGES; s++) begin
        tag_vld[s]  <= tag_vld[s-1];
        tag_id[s]   <= tag_id[s-1];
        tag_zero[s] <= tag_zero[s-1];
      end
    end
  end

  assign cap      = tag_vld[STAGES-1];
  assign cap_id   = tag_id[STAGES-1];
  assign cap_zero = tag_zero[STAGES-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 4'b0000;
      rsp_y     <= 32'h0;
      in_flight <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cap && cap_id == 2'(i)) begin
          rsp_valid[i]     <= 1'b1;
          rsp_y[8*i +: 8]  <= cap_zero ? 8'h00 : alu_y;
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
        in_flight[i] <= (in_flight[i] | (issue && win == 2'(i))) & ~(cap && cap_id == 2'(i));
      end
    end
  end

  assign busy = (|in_flight) | (|rsp_valid);

endmodule

// File: tb/tb_alu_e4m3_scheduler.sv
// Bench for alu_e4m3_scheduler: randomized requesters, an e4m3 ALU stand-in, and a
// scoreboard monitor with a round-robin reference model.
module tb_alu_e4m3_scheduler;
  localparam int LAT = 1;

  logic        clock;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  req_op;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [31:0] rsp_y;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_ctrl;
  logic [7:0]  alu_y;
  logic        busy;
  logic [15:0] issue_count;

  alu_e4m3_scheduler #(.ALU_LATENCY(LAT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_y(alu_y),
    .busy(busy), .issue_count(issue_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // e4m3 arithmetic in real numbers; encoding picks the nearest representable value.
  function automatic real p2(input int e);
    real r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real dec(input logic [7:0] c);
    real v;
    if (c[6:0] == 7'h7F) v = 0.0;
    else if (c[6:3] == 4'd0) v = real'(c[2:0]) * p2(-9);
    else v = (8.0 + real'(c[2:0])) * p2(int'(c[6:3]) - 10);
    return c[7] ? -v : v;
  endfunction

  function automatic logic [7:0] enc(input real x);
    real ax = (x < 0.0) ? -x : x;
    real best = 1.0e30;
    real d;
    logic [7:0] bc = 8'h00;
    for (int c = 0; c < 127; c++) begin
      d = dec(8'(c)) - ax;
      if (d < 0.0) d = -d;
      if (d < best) begin
        best = d;
        bc = 8'(c);
      end
    end
    if (x < 0.0 && bc != 8'h00) bc[7] = 1'b1;
    return bc;
  endfunction

  function automatic logic [7:0] e4m3(input logic [7:0] a, input logic [7:0] b, input logic [3:0] ctrl);
    case (ctrl)
      4'd1:    return enc(dec(a) + dec(b));
      4'd2:    return enc(dec(a) * dec(b));
      default: return 8'h5A;
    endcase
  endfunction

  // ALU stand-in with LAT cycles of latency.
  logic [7:0] alu_pipe [0:4];
  always @(posedge clock) begin
    alu_pipe[0] <= e4m3(alu_a, alu_b, alu_ctrl);
    for (int k = 1; k < 5; k++) alu_pipe[k] <= alu_pipe[k-1];
  end
  generate
    if (LAT == 0) begin : g_comb
      assign alu_y = e4m3(alu_a, alu_b, alu_ctrl);
    end else begin : g_pipe
      assign alu_y = alu_pipe[LAT-1];
    end
  endgenerate

  // Scoreboard and reference model state (written only by the monitor).
  typedef struct { int t; logic [7:0] y; } exp_t;
  typedef struct { int cyc; int id; } g_t;
  exp_t       q [4][$];
  g_t         glog [$];
  logic [3:0] m_out;
  int         m_ptr;
  logic [15:0] m_cnt;
  int         m_tot;
  int         acc_cnt [4];
  logic [7:0] last_y [4];
  logic       p_iss;
  logic [3:0] p_ctrl;
  logic [7:0] p_a, p_b;
  logic [3:0] p_rv;
  logic [7:0] p_y [4];
  int         m_win;
  logic [3:0] m_rdy;
  logic [7:0] ha, hb;
  logic [1:0] hop;

  initial begin
    m_out = 0; m_ptr = 0; m_cnt = 0; m_tot = 0; p_iss = 0; p_rv = 0;
    for (int i = 0; i < 4; i++) begin
      acc_cnt[i] = 0;
      last_y[i] = 8'hFF;
      p_y[i] = 8'h00;
    end
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        for (int i = 0; i < 4; i++) q[i].delete();
        m_out = 0; m_ptr = 0; m_cnt = 0; m_tot = 0; p_iss = 0; p_rv = 0;
      end else begin
        m_win = -1;
        for (int k = 0; k < 4; k++)
          if (m_win < 0 && req_valid[(m_ptr + k) % 4] && !m_out[(m_ptr + k) % 4]) m_win = (m_ptr + k) % 4;
        m_rdy = (m_win < 0) ? 4'b0000 : (4'b0001 << m_win);
        chk("req_ready", {28'h0, req_ready}, {28'h0, m_rdy});
        chk("busy", {31'h0, busy}, {31'h0, |m_out});
        chk("issue_count", {16'h0, issue_count}, {16'h0, m_cnt});
        if (p_iss) begin
          chk("alu_ctrl", {28'h0, alu_ctrl}, {28'h0, p_ctrl});
          chk("alu_a", {24'h0, alu_a}, {24'h0, p_a});
          chk("alu_b", {24'h0, alu_b}, {24'h0, p_b});
        end else begin
          chk("alu_idle", {28'h0, alu_ctrl}, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
          if (req_ready[i] && req_valid[i]) glog.push_back('{cyc, i});
          if (rsp_valid[i]) begin
            if (q[i].size() == 0) begin
              total++;
              bad++;
              $display("FAIL rsp_spurious[%0d]: got rsp_valid=1 want 0 (cycle %0d)", i, cyc);
            end else begin
              if (!p_rv[i]) chk("rsp_latency", cyc, q[i][0].t + 2 + LAT);
              else chk("rsp_hold", {24'h0, rsp_y[8*i +: 8]}, {24'h0, p_y[i]});
              if (rsp_ready[i]) begin
                chk("rsp_y", {24'h0, rsp_y[8*i +: 8]}, {24'h0, q[i][0].y});
                last_y[i] = rsp_y[8*i +: 8];
                void'(q[i].pop_front());
                m_out[i] = 1'b0;
              end
            end
          end
          p_rv[i] = rsp_valid[i] & ~rsp_ready[i];
          p_y[i]  = rsp_y[8*i +: 8];
        end
        if (m_win >= 0) begin
          ha  = req_a[8*m_win +: 8];
          hb  = req_b[8*m_win +: 8];
          hop = req_op[2*m_win +: 2];
          q[m_win].push_back('{cyc, (hop == 2'b01) ? e4m3(ha, hb, 4'd1) :
                                   (hop == 2'b10) ? e4m3(ha, hb, 4'd2) : 8'h00});
          m_out[m_win] = 1'b1;
          m_ptr = (m_win + 1) % 4;
          m_cnt++;
          m_tot++;
          acc_cnt[m_win]++;
          p_iss  = 1'b1;
          p_ctrl = (hop == 2'b01) ? 4'd1 : (hop == 2'b10) ? 4'd2 : 4'd0;
          p_a    = ha;
          p_b    = hb;
        end else begin
          p_iss = 1'b0;
        end
      end
    end
  end

  // Requester driver state (written only by the main process).
  logic [3:0] pv;
  logic [7:0] pa [4];
  logic [7:0] pb [4];
  logic [1:0] pop [4];
  int         seen [4];
  logic [3:0] gen_mask;
  logic [3:0] hold_low;
  int         gen_pct, rdy_pct, fix_op;
  logic [7:0] fix_a, fix_b;

  task automatic drive();
    req_valid = pv;
    for (int i = 0; i < 4; i++) begin
      req_a[8*i +: 8]  = pa[i];
      req_b[8*i +: 8]  = pb[i];
      req_op[2*i +: 2] = pop[i];
    end
  endtask

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc_cnt[i] != seen[i]) begin
          seen[i] = acc_cnt[i];
          pv[i] = 1'b0;
        end
        if (!pv[i] && gen_mask[i] && $urandom_range(99) < gen_pct) begin
          pv[i]  = 1'b1;
          pa[i]  = (fix_op < 0) ? 8'($urandom) : fix_a;
          pb[i]  = (fix_op < 0) ? 8'($urandom) : fix_b;
          pop[i] = (fix_op < 0) ? 2'($urandom) : 2'(fix_op);
        end
        rsp_ready[i] = !hold_low[i] && ($urandom_range(99) < rdy_pct);
      end
      drive();
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, {28'h0, req_ready}, 32'h0);
    chk({tag, "_rsp_valid"}, {28'h0, rsp_valid}, 32'h0);
    chk({tag, "_rsp_y"}, rsp_y, 32'h0);
    chk({tag, "_alu_a"}, {24'h0, alu_a}, 32'h0);
    chk({tag, "_alu_b"}, {24'h0, alu_b}, 32'h0);
    chk({tag, "_alu_ctrl"}, {28'h0, alu_ctrl}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_issue_count"}, {16'h0, issue_count}, 32'h0);
  endtask

  int base, pcyc, rel_cyc, n1, n;

  initial begin
    reset_n = 1'b1;
    pv = 0; gen_mask = 0; hold_low = 0; gen_pct = 100; rdy_pct = 100; fix_op = -1;
    fix_a = 0; fix_b = 0; rsp_ready = 0;
    for (int i = 0; i < 4; i++) begin
      pa[i] = 0; pb[i] = 0; pop[i] = 0; seen[i] = 0;
    end
    drive();
    #1 reset_n = 1'b0;
    #1 chk_reset("rst_init");
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;

    // All four request mul 2.0*2.0 at once: grants 0..3 back to back, each 4.0.
    base = glog.size();
    gen_mask = 4'hF; fix_op = 2; fix_a = 8'h40; fix_b = 8'h40;
    step(1);
    gen_mask = 0;
    step(12);
    chk("rr_grants", glog.size() - base, 4);
    if (glog.size() >= base + 4)
      for (int k = 0; k < 4; k++) begin
        chk("rr_id", glog[base+k].id, k);
        chk("rr_cycle", glog[base+k].cyc, glog[base].cyc + k);
      end
    for (int i = 0; i < 4; i++) chk("mul_y", {24'h0, last_y[i]}, 32'h48);

    // Single add 1.0+1.0 from requester 0.
    base = glog.size();
    gen_mask = 4'h1; fix_op = 1; fix_a = 8'h38; fix_b = 8'h38;
    step(1);
    gen_mask = 0;
    step(8);
    chk("single_grants", glog.size() - base, 1);
    if (glog.size() > base) chk("single_id", glog[base].id, 0);
    chk("add_y", {24'h0, last_y[0]}, 32'h40);

    // Requester 1 keeps requesting while its response is held.
    base = glog.size();
    hold_low = 4'h2; gen_mask = 4'h2; fix_op = 1; fix_a = 8'h30; fix_b = 8'h28;
    step(12);
    n1 = 0;
    for (int k = base; k < glog.size(); k++) if (glog[k].id == 1) n1++;
    chk("held_one_grant", n1, 1);
    hold_low = 4'h0;
    step(1);
    pcyc = cyc;
    hold_low = 4'h2;
    step(3);
    n1 = 0;
    for (int k = base; k < glog.size(); k++)
      if (glog[k].id == 1) begin
        n1++;
        if (n1 == 2) chk("regrant_cycle", glog[k].cyc, pcyc + 1);
      end
    chk("regrant_count", n1, 2);
    hold_low = 0; gen_mask = 0;
    step(8);

    // Illegal opcode from requester 2.
    base = glog.size();
    gen_mask = 4'h4; fix_op = 3; fix_a = 8'h44; fix_b = 8'h44;
    step(1);
    gen_mask = 0;
    step(8);
    if (glog.size() > base) chk("illegal_id", glog[base].id, 2);
    else chk("illegal_grants", glog.size() - base, 1);
    chk("illegal_y", {24'h0, last_y[2]}, 32'h0);

    // Reset with two operations in flight, then a request in the first cycle after release.
    hold_low = 4'hF; gen_mask = 4'h3; fix_op = 2; fix_a = 8'h40; fix_b = 8'h38;
    step(1);
    gen_mask = 0;
    step(1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 chk_reset("rst_mid");
    pv = 0;
    for (int i = 0; i < 4; i++) seen[i] = acc_cnt[i];
    drive();
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    base = glog.size();
    rel_cyc = cyc;
    pv[3] = 1'b1; pa[3] = 8'h38; pb[3] = 8'h30; pop[3] = 2'b01;
    drive();
    hold_low = 0;
    step(12);
    if (glog.size() > base) begin
      chk("post_rst_id", glog[base].id, 3);
      chk("post_rst_cycle", glog[base].cyc, rel_cyc);
    end else chk("post_rst_grants", glog.size() - base, 1);

    // Random traffic with random response backpressure.
    gen_mask = 4'hF; fix_op = -1; gen_pct = 50; rdy_pct = 70;
    step(2000);

    // Saturate until 65536 accepted since the last reset; the counter must wrap.
    gen_pct = 100; rdy_pct = 100;
    n = 0;
    while (m_tot < 65536 && n < 80000) begin
      step(1);
      n++;
    end
    chk("wrap_reached", m_tot, 65536);
    chk("wrap_count", {16'h0, issue_count}, 32'h0);

    gen_mask = 0;
    step(20);
    for (int i = 0; i < 4; i++) chk("drain", q[i].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_e4m3_scheduler.md
ALU_E4M3_SCHEDULER -- requirements
Module: alu_e4m3_scheduler

Interface
REQ-001 SHALL have parameter ALU_LATENCY, default 1: cycles from alu_a/alu_b/alu_ctrl to a valid alu_y; legal range 0..4.
REQ-002 SHALL have port clock  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  4  per-requester operation request.
REQ-005 SHALL have port req_ready  output  4  per-requester grant; transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-006 SHALL have port req_a  input  32  operand A, 8 bits per requester, requester i at bits [8i+7:8i].
REQ-007 SHALL have port req_b  input  32  operand B, packed as req_a.
REQ-008 SHALL have port req_op  input  8  2 bits per requester: 01 add, 10 mul, 00/11 illegal.
REQ-009 SHALL have port rsp_valid  output  4  per-requester result available.
REQ-010 SHALL have port rsp_ready  input  4  per-requester result accept.
REQ-011 SHALL have port rsp_y  output  32  e4m3 result, packed as req_a.
REQ-012 SHALL have port alu_a  output  8  operand A to the shared e4m3 ALU.
REQ-013 SHALL have port alu_b  output  8  operand B to the shared e4m3 ALU.
REQ-014 SHALL have port alu_ctrl  output  4  ALU op code: 0001 add, 0010 mul, 0000 idle.
REQ-015 SHALL have port alu_y  input  8  ALU result.
REQ-016 SHALL have port busy  output  1  high while any operation is in flight or any rsp_valid is high.
REQ-017 SHALL have port issue_count  output  16  count of accepted requests.

Function
REQ-018 SHALL accept at most one request per cycle.
REQ-019 SHALL treat requester i as eligible when req_valid[i] is high, it has no operation in flight, and rsp_valid[i] is low; this includes the cycle in which rsp_valid[i] and rsp_ready[i] handshake.
REQ-020 SHALL arbitrate round-robin: search order starts at pointer ptr (2 bits) and ascends modulo 4; the first eligible requester wins.
REQ-021 SHALL drive req_ready combinationally: high only for the winner, so req_ready is one-hot or zero.
REQ-022 SHALL update ptr to (winner+1) mod 4 on a handshake edge and hold ptr in cycles with no grant.
REQ-023 SHALL register the winner's operands on the handshake edge (cycle T), so alu_a, alu_b and alu_ctrl are valid throughout cycle T+1.
REQ-024 SHALL map req_op 01 to alu_ctrl 0001 and 10 to 0010; illegal codes SHALL issue alu_ctrl 0000 and still return a response, with rsp_y = 0x00.
REQ-025 SHALL drive alu_ctrl 0000 and hold alu_a/alu_b at their previous values in any cycle with no issue.
REQ-026 SHALL carry a {valid, 2-bit id} tag through an ALU_LATENCY+1 stage shift register alongside each issue.
REQ-027 SHALL capture alu_y into the rsp_y slot of the tagged id at the end of cycle T+1+ALU_LATENCY.
REQ-028 SHALL assert rsp_valid[id] from cycle T+2+ALU_LATENCY, holding rsp_valid and rsp_y stable until rsp_ready[id].
REQ-029 SHALL clear rsp_valid[i] on the edge where rsp_valid[i] and rsp_ready[i] are both high; a grant to i is possible from the following cycle.
REQ-030 SHALL process back-to-back issues from different requesters every cycle, with no bubbles.
REQ-031 SHALL accept simultaneous completion of one requester and a new grant to another in the same cycle, with both honoured.
REQ-032 SHALL increment issue_count on each handshake, wrapping from 0xFFFF to 0x0000.
REQ-033 SHALL ignore req_a, req_b and req_op of non-granted requesters.

Reset
REQ-034 SHALL, while reset_n is low, asynchronously force: req_ready=0, rsp_valid=0, rsp_y=0, alu_a=0, alu_b=0, alu_ctrl=0000, ptr=0, all tags invalid, issue_count=0, busy=0.
REQ-035 SHALL discard all in-flight operations on a reset asserted mid-operation, producing no response for them after release.
REQ-036 SHALL allow the first grant in the first cycle after reset_n deasserts and is sampled high.

Verification
REQ-037 SHALL be verified by: single request, ALU_LATENCY=1, req 0 add 0x38+0x38 handshake in cycle T -> alu_ctrl=0001 in T+1; rsp_valid[0] in T+3 with rsp_y=0x40.
REQ-038 SHALL be verified by: all four req_valid held high, each op mul 0x40*0x40 -> grants 0,1,2,3 on consecutive cycles; every rsp_y=0x48; ptr returns to 0.
REQ-039 SHALL be verified by: req 1 with rsp_ready[1] held low and req_valid[1] held high -> no second grant to 1; rsp_y[15:8] stable; regrant the cycle after rsp_ready[1] is pulsed.
REQ-040 SHALL be verified by: req_op=11 from requester 2 -> alu_ctrl=0000; rsp_valid[2] with rsp_y=0x00.
REQ-041 SHALL be verified by: reset_n pulsed low while 2 operations are in flight -> all outputs 0 immediately; no rsp_valid after release; issue_count=0.
REQ-042 SHALL be verified by: 65536 accepted requests -> issue_count wraps to 0x0000.
